dct_transpose_reader: RTL and testbench
=======================================

Name: dct_transpose_reader

Overview:
Read-side partner of the column-collecting DCT stage-1 buffer. It captures a completed 8x8 column-major block when stage 1 signals done and buffers it in one of two ping-pong banks. It then streams the block out transposed, one 8-element row per handshake, to the stage-2 row DCT. Capturing the next block overlaps with streaming the current one.

Parameters:
SIZE, 10, signed element width (stage-1 output width, input SIZE+2)
DIM, 8, block dimension; fixed at 8, other values unsupported

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
blk_in  input  [7:0][7:0]xSIZE signed  stage-1 block, blk_in[c][k] = column c, element k
blk_valid  input  1  single-cycle pulse: blk_in complete (stage-1 done)
blk_ready  output  1  a free bank exists; capture happens only if high
row_out  output  [7:0]xSIZE signed  row r: row_out[c] = block[c][r]
row_idx  output  3  index r of row currently presented
row_last  output  1  high when row_idx==7 and row_valid
row_valid  output  1  row_out valid
row_ready  input  1  stage-2 accepts row
overflow  output  1  sticky: blk_valid arrived while blk_ready low
busy  output  1  any bank full

Behaviour:
- State: bank0/bank1 (64xSIZE each), bank_full[1:0], wr_bank, rd_bank, row_cnt[2:0], overflow.
- Reset (async, rst=1): bank_full=0, wr_bank=0, rd_bank=0, row_cnt=0, overflow=0. Bank contents are cleared to 0. Outputs during and after reset: row_valid=0, row_last=0, row_idx=0, busy=0, overflow=0, blk_ready=1, row_out=0.
- blk_ready = ~bank_full[wr_bank]. It is purely registered-state derived, with no combinational path from row_ready or blk_valid.
- Capture: on an edge with blk_valid&&blk_ready:
  - all 64 elements of blk_in are written into bank[wr_bank];
  - bank_full[wr_bank] is set;
  - wr_bank toggles.
- Drop: blk_valid&&!blk_ready leaves banks unchanged and sets overflow. overflow clears only on rst.
- Read side: row_valid = bank_full[rd_bank]; row_out[c] = bank[rd_bank][c][row_cnt]; row_idx = row_cnt.
  - Latency: a block captured at edge N presents row 0 from edge N (visible in the cycle following N) when rd_bank is that bank.
- Transfer on an edge with row_valid&&row_ready:
  - row_cnt increments.
  - If row_cnt==7: row_cnt wraps to 0, bank_full[rd_bank] clears, rd_bank toggles.
- No transfer: row_out, row_idx and row_valid hold stable (standard valid/ready; valid never drops without transfer except on rst).
- Read FSM per bank: EMPTY -> FULL (capture) -> EMPTY (row 7 transfer).
  - Both banks FULL: blk_ready=0.
  - Both EMPTY: row_valid=0.
- Simultaneous capture and final-row release:
  - Capture writes wr_bank and release clears rd_bank. These are different banks whenever blk_ready=1, so both take effect in the same edge.
  - If both banks were full, blk_ready was 0 and the incoming block is dropped even though a bank frees that edge.
- Back-to-back full throughput: row_ready held high gives 8 rows per 8 cycles with no bubble between blocks if the next bank is full.
- Arithmetic: none. Elements pass bit-exact, sign preserved.
- rst mid-stream aborts everything. Partially streamed rows are discarded with no further row_valid.

Test Plan:
- Single block, blk_in[c][k]=16*c+k, row_ready=1 -> 8 consecutive rows, row r: row_out[c]=16*c+r; row_idx 0..7; row_last only on row 7; then row_valid=0, busy=0.
- Backpressure: row_ready low cycles 2-4 of stream -> row_out/row_idx held (row 2 held 3 cycles); all 8 rows delivered exactly once, in order.
- Ping-pong: second block (values -(16*c+k)) pulsed while block 1 streaming -> blk_ready stays 1, no overflow; row 7 of block 1 followed next cycle by row 0 of block 2 (row_out[0]=0, row_out[1]=-16).
- Overflow: row_ready=0, three blk_valid pulses -> blocks 1,2 captured, blk_ready=0 after second, third dropped, overflow=1 sticky; streaming then yields only blocks 1 and 2.
- Simultaneous: both banks full, blk_valid on the same edge as block-1 row-7 transfer -> block dropped, overflow=1, blk_ready=1 next cycle.
- Async reset mid-stream (after row 3) -> row_valid=0, blk_ready=1, busy=0 immediately without clock edge; new block afterwards streams from row 0 correctly.

Source files
------------

// File: rtl/dct_transpose_reader.sv
// Ping-pong transpose buffer between the column DCT and the row DCT.
// It captures 8x8 column-major blocks and streams them out one row per valid/ready handshake.
module dct_transpose_reader #(
  parameter int SIZE = 10,
  parameter int DIM  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [DIM-1:0][DIM-1:0][SIZE-1:0] blk_in,
  input  logic                                    blk_valid,
  output logic                                    blk_ready,
  output logic signed [DIM-1:0][SIZE-1:0]          row_out,
  output logic [2:0]                              row_idx,
  output logic                                    row_last,
  output logic                                    row_valid,
  input  logic                                    row_ready,
  output logic                                    overflow,
  output logic                                    busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

  bank_state_e                          state_q [2];
  bank_state_e                          state_d [2];
  logic [DIM-1:0][DIM-1:0][SIZE-1:0]    bank_q  [2];
  logic                                 wr_bank_q, wr_bank_d;
  logic                                 rd_bank_q, rd_bank_d;
  logic [2:0]                           row_cnt_q, row_cnt_d;
  logic                                 overflow_q, overflow_d;
  logic                                 capture, xfer, last_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      row_cnt_q  <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Capture and final-row release always target different banks when blk_ready is high,
  // so both updates can be applied independently in the same cycle.
  always_comb begin
    capture    = blk_valid && blk_ready;
    xfer       = row_valid && row_ready;
    last_xfer  = xfer && (row_cnt_q == 3'd7);
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q || (blk_valid && !blk_ready);
    if (capture) begin
      state_d[wr_bank_q] = FULL;
      wr_bank_d          = ~wr_bank_q;
    end
    if (xfer) begin
      row_cnt_d = row_cnt_q + 3'd1;
    end
    if (last_xfer) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_comb begin
    blk_ready = (state_q[wr_bank_q] == EMPTY);
    row_valid = (state_q[rd_bank_q] == FULL);
    busy      = (state_q[0] == FULL) || (state_q[1] == FULL);
    row_idx   = row_cnt_q;
    row_last  = row_valid && (row_cnt_q == 3'd7);
    overflow  = overflow_q;
    for (int c = 0; c < DIM; c++) begin
      row_out[c] = bank_q[rd_bank_q][c][row_cnt_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else if (capture) begin
      bank_q[wr_bank_q] <= blk_in;
    end
  end

endmodule

// File: tb/tb_dct_transpose_reader.sv
// Directed bench for dct_transpose_reader: single block, backpressure, ping-pong,
// overflow, simultaneous capture/release and asynchronous reset.
module tb_dct_transpose_reader;

  localparam int SIZE = 10;

  logic                                clk = 1'b0;
  logic                                rst;
  logic signed [7:0][7:0][SIZE-1:0]    blk_in;
  logic                                blk_valid;
  logic                                blk_ready;
  logic signed [7:0][SIZE-1:0]         row_out;
  logic [2:0]                          row_idx;
  logic                                row_last;
  logic                                row_valid;
  logic                                row_ready;
  logic                                overflow;
  logic                                busy;

  int total = 0;
  int bad   = 0;

  dct_transpose_reader #(.SIZE(SIZE), .DIM(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_in    (blk_in),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .row_out   (row_out),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Block pattern: element (c,k) = sgn*(16*c+k).
  function automatic logic [7:0][7:0][SIZE-1:0] make_blk(input int sgn);
    logic [7:0][7:0][SIZE-1:0] b;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++)
        b[c][k] = SIZE'(sgn * (16 * c + k));
    return b;
  endfunction

  function automatic logic [7:0][SIZE-1:0] exp_row(input int sgn, input int r);
    logic [7:0][SIZE-1:0] v;
    for (int c = 0; c < 8; c++) v[c] = SIZE'(sgn * (16 * c + r));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b0; row_ready = 1'b0; blk_in = '0;
    tick(); tick();
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL reset_row_valid got=%b exp=0", row_valid); end
    total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL reset_blk_ready got=%b exp=1", blk_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (row_idx !== 3'd0) begin bad++; $display("FAIL reset_row_idx got=%0d exp=0", row_idx); end
    total++; if (row_last !== 1'b0) begin bad++; $display("FAIL reset_row_last got=%b exp=0", row_last); end
    total++; if (row_out !== '0) begin bad++; $display("FAIL reset_row_out got=%h exp=0", row_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL single_ready_pre got=%b exp=1", blk_ready); end
    blk_in = make_blk(1); blk_valid = 1'b1; row_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      total++; if (row_valid !== 1'b1) begin bad++; $display("FAIL single_valid r=%0d got=%b exp=1", r, row_valid); end
      total++; if (row_idx !== 3'(r)) begin bad++; $display("FAIL single_idx got=%0d exp=%0d", row_idx, r); end
      total++; if (row_out !== exp_row(1, r)) begin bad++; $display("FAIL single_row r=%0d got=%h exp=%h", r, row_out, exp_row(1, r)); end
      total++; if (row_last !== (r == 7)) begin bad++; $display("FAIL single_last r=%0d got=%b exp=%b", r, row_last, (r == 7)); end
      tick();
    end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL single_valid_end got=%b exp=0", row_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int er;
    er = 0;
    blk_in = make_blk(1); blk_valid = 1'b1; row_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && er < 8; cyc++) begin
      row_ready = !(cyc >= 2 && cyc <= 4);
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(er) || row_out !== exp_row(1, er)) begin
        bad++; $display("FAIL bp_row cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", cyc, row_valid, row_idx, row_out, er, exp_row(1, er));
      end
      tick();
      if (row_ready) er++;
    end
    total++; if (er !== 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", er); end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_end got=%b exp=0", row_valid); end
  endtask

  task automatic test_pingpong();
    blk_in = make_blk(1); blk_valid = 1'b1; row_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL pp_ready got=%b exp=1", blk_ready); end
        blk_in = make_blk(-1); blk_valid = 1'b1;
      end
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(i % 8) || row_out !== exp_row(i < 8 ? 1 : -1, i % 8)) begin
        bad++; $display("FAIL pp_row i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, row_valid, row_idx, row_out, i % 8, exp_row(i < 8 ? 1 : -1, i % 8));
      end
      tick();
      blk_valid = 1'b0;
    end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL pp_valid_end got=%b exp=0", row_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    row_ready = 1'b0;
    blk_in = make_blk(1); blk_valid = 1'b1;
    tick();
    total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL ov_ready1 got=%b exp=1", blk_ready); end
    blk_in = make_blk(-1);
    tick();
    total++; if (blk_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ov_ready2 got=%b/%b exp=0/1", blk_ready, busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_early got=%b exp=0", overflow); end
    blk_in = make_blk(2);
    tick();
    blk_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", overflow); end
    row_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(i % 8) || row_out !== exp_row(i < 8 ? 1 : -1, i % 8)) begin
        bad++; $display("FAIL ov_row i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, row_valid, row_idx, row_out, i % 8, exp_row(i < 8 ? 1 : -1, i % 8));
      end
      tick();
    end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL ov_valid_end got=%b exp=0", row_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; row_ready = 1'b0; blk_valid = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_ov_clear got=%b exp=0", overflow); end
    blk_in = make_blk(1); blk_valid = 1'b1;
    tick();
    blk_in = make_blk(-1);
    tick();
    blk_valid = 1'b0;
    row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) begin
        total++; if (blk_ready !== 1'b0) begin bad++; $display("FAIL sim_ready_pre got=%b exp=0", blk_ready); end
        blk_in = make_blk(2); blk_valid = 1'b1;
      end
      tick();
      blk_valid = 1'b0;
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sim_overflow got=%b exp=1", overflow); end
    total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL sim_ready_post got=%b exp=1", blk_ready); end
    for (int r = 0; r < 8; r++) begin
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(r) || row_out !== exp_row(-1, r)) begin
        bad++; $display("FAIL sim_row r=%0d got=%b/%0d/%h exp=1/%0d/%h", r, row_valid, row_idx, row_out, r, exp_row(-1, r));
      end
      tick();
    end
    total++; if (row_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sim_end got=%b/%b exp=0/0", row_valid, busy); end
  endtask

  task automatic test_async_reset();
    blk_in = make_blk(1); blk_valid = 1'b1; row_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int r = 0; r < 4; r++) tick();
    total++; if (row_idx !== 3'd4 || row_valid !== 1'b1) begin bad++; $display("FAIL ar_mid got=%0d/%b exp=4/1", row_idx, row_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", row_valid); end
    total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", blk_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    total++; if (row_idx !== 3'd0) begin bad++; $display("FAIL ar_idx got=%0d exp=0", row_idx); end
    tick();
    rst = 1'b0;
    blk_in = make_blk(-1); blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(r) || row_out !== exp_row(-1, r)) begin
        bad++; $display("FAIL ar_row r=%0d got=%b/%0d/%h exp=1/%0d/%h", r, row_valid, row_idx, row_out, r, exp_row(-1, r));
      end
      tick();
    end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL ar_valid_end got=%b exp=0", row_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_pingpong();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
